// File: rtl/spi_master_ctrl.sv
// SPI master for the register-access slave: CPOL=0, launch on rise,
// slave samples on fall. One start = one 16-clk write or 24-clk read frame.
module spi_master_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_sclk,
  output logic       o_cs,
  output logic       o_mosi,
  input  logic       i_miso
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_hcnt;
  logic [4:0]    r_bit;
  logic [7:0]    r_cnt;
  logic [23:0]   r_tx;
  logic [7:0]    r_rx;
  logic          r_rw;
  logic          r_m1;
  logic          r_m2;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_rdata;
  logic          r_sclk;
  logic          r_cs;
  logic          r_mosi;

  logic          w_half_end;
  logic [4:0]    w_n;

  assign w_half_end = (r_hcnt == HW'(CLK_DIV - 1));
  assign w_n        = r_rw ? 5'd24 : 5'd16;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rw    <= 1'b0;
      r_m1    <= 1'b0;
      r_m2    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= '0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_m1   <= i_miso;
      r_m2   <= r_m1;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_bit  <= '0;
          r_hcnt <= '0;
          r_cnt  <= '0;
          if (i_start) begin
            r_rw    <= i_rw;
            r_tx    <= {i_rw, 5'b0, i_addr,
                        (i_rw ? 8'h00 : i_wdata), 8'h00};
            r_busy  <= 1'b1;
            r_cs    <= 1'b0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == 8'(CS_SETUP)) begin
            r_sclk  <= 1'b1;
            r_mosi  <= r_tx[23];
            r_tx    <= {r_tx[22:0], 1'b0};
            r_bit   <= 5'd1;
            r_hcnt  <= '0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SHIFT: begin
          if (!w_half_end) begin
            r_hcnt <= r_hcnt + 1'b1;
          end else begin
            r_hcnt <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
              // read data occupies the last byte of a read frame
              if (r_rw && r_bit >= 5'd17)
                r_rx <= {r_rx[6:0], r_m2};
            end else if (r_bit == w_n) begin
              r_mosi  <= 1'b0;
              r_state <= S_HOLD;
            end else begin
              r_sclk <= 1'b1;
              r_mosi <= r_tx[23];
              r_tx   <= {r_tx[22:0], 1'b0};
              r_bit  <= r_bit + 5'd1;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == 8'(CS_HOLD - 1)) begin
            r_cs    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 8'(CS_IDLE - 1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (r_rw) r_rdata <= r_rx;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_rdata = r_rdata;
  assign o_sclk  = r_sclk;
  assign o_cs    = r_cs;
  assign o_mosi  = r_mosi;

endmodule
